// File: rtl/stream_cipher_pkg.sv
// Shared constants and types for the stream cipher datapath.
// Destination tags name the consumers the router feeds.
package stream_cipher_pkg;
  localparam int DATA_W    = 8;
  localparam int DEST_KEY  = 0;
  localparam int DEST_DATA = 1;

  typedef logic [DATA_W-1:0] word_t;
endpackage

// File: rtl/router_fifo.sv
// First-word-fallthrough FIFO used as one destination queue inside stream_router.
// Pointers wrap naturally; occupancy is held in its own counter.
module router_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         push,
  input  logic [DATA_W-1:0]            wdata,
  input  logic                         pop,
  output logic [DATA_W-1:0]            rdata,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH):0]       level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wptr;
  logic [AW-1:0]     r_rptr;
  logic [LW-1:0]     r_level;
  logic              w_push;
  logic              w_pop;

  assign full   = (r_level == LW'(DEPTH));
  assign empty  = (r_level == '0);
  assign level  = r_level;
  assign rdata  = r_mem[r_rptr];
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else if (flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  // Storage is deliberately not reset or flushed; only the pointers define contents.
  always_ff @(posedge clk) begin
    if (w_push && !flush) r_mem[r_wptr] <= wdata;
  end
endmodule

// File: rtl/stream_router.sv
// Steers tagged words into per-destination FIFOs; out-of-range tags are dropped and counted.
// A stalled consumer only back-pressures words addressed to its own FIFO.
module stream_router #(
  parameter int DATA_W     = stream_cipher_pkg::DATA_W,
  parameter int NUM_DEST   = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int TAG_W      = 2
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        flush,
  input  logic [DATA_W-1:0]                           in_data,
  input  logic [TAG_W-1:0]                            in_dest,
  input  logic                                        in_valid,
  output logic                                        in_ready,
  output logic [NUM_DEST*DATA_W-1:0]                  out_data,
  output logic [NUM_DEST-1:0]                         out_valid,
  input  logic [NUM_DEST-1:0]                         out_ready,
  output logic [NUM_DEST*$clog2(FIFO_DEPTH+1)-1:0]    level,
  output logic [7:0]                                  drop_count,
  output logic                                        err_sticky
);
  localparam int LW = $clog2(FIFO_DEPTH + 1);

  logic [NUM_DEST-1:0] w_full;
  logic [NUM_DEST-1:0] w_empty;
  logic [NUM_DEST-1:0] w_push;
  logic [NUM_DEST-1:0] w_sel;
  logic                w_tag_ok;
  logic                w_dest_full;
  logic                w_accept;
  logic                w_drop;
  logic [7:0]          r_drop_count;
  logic                r_err_sticky;

  // Decode by equality so no index wider than the FIFO vector is ever formed.
  always_comb begin
    w_sel       = '0;
    w_tag_ok    = 1'b0;
    w_dest_full = 1'b0;
    for (int i = 0; i < NUM_DEST; i++) begin
      if (in_dest == TAG_W'(i)) begin
        w_sel[i]    = 1'b1;
        w_tag_ok    = 1'b1;
        w_dest_full = w_full[i];
      end
    end
  end

  assign in_ready = !flush && (!w_tag_ok || !w_dest_full);
  assign w_accept = in_valid && in_ready;
  assign w_push   = w_accept ? w_sel : '0;
  assign w_drop   = w_accept && !w_tag_ok;

  for (genvar g = 0; g < NUM_DEST; g++) begin : g_fifo
    router_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .push  (w_push[g]),
      .wdata (in_data),
      .pop   (out_ready[g]),
      .rdata (out_data[g*DATA_W +: DATA_W]),
      .full  (w_full[g]),
      .empty (w_empty[g]),
      .level (level[g*LW +: LW])
    );
    assign out_valid[g] = !w_empty[g];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_drop_count <= '0;
      r_err_sticky <= 1'b0;
    end else if (flush) begin
      r_drop_count <= '0;
      r_err_sticky <= 1'b0;
    end else if (w_drop) begin
      if (r_drop_count != 8'hFF) r_drop_count <= r_drop_count + 1'b1;
      r_err_sticky <= 1'b1;
    end
  end

  assign drop_count = r_drop_count;
  assign err_sticky = r_err_sticky;
endmodule
